// File: rtl/multdiv_unit.sv
// HI/LO multiply-divide unit: MULT/MULTU/DIV/DIVU with fixed busy latency, MTHI/MTLO single-cycle writes.
// Latency: MULT/MULTU and DIV/DIVU results land in hi/lo K+1 cycles after the start cycle; MTHI/MTLO land the next cycle.
// Backpressure: busy (combinational in the start cycle) stalls the pipeline; starts seen while not IDLE are ignored.
module multdiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        dis,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic             op_long;
    logic             op_valid;
    logic             accept;

    logic [63:0]      a_ext, b_ext, prod;
    logic             neg_a, neg_b;
    logic [31:0]      mag_a, mag_b;
    logic [31:0]      uquo, urem;
    logic [31:0]      quo, rem;

    // Op classification: long ops raise busy, MTHI/MTLO do not; 0 and 7 are no-ops.
    always_comb begin
        op_long  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        op_valid = op_long || (op == OP_MTHI) || (op == OP_MTLO);
        accept   = start && !dis && op_valid && (state_q == ST_IDLE);
    end

    // Busy covers the start cycle combinationally; held low while reset is asserted.
    always_comb begin
        busy = reset_n && ((state_q != ST_IDLE) || (start && !dis && op_long));
    end

    // 64-bit product of the latched operands; sign-extension makes one multiplier serve both forms.
    always_comb begin
        a_ext = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        b_ext = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = a_ext * b_ext;
    end

    // Divide on magnitudes and fix signs afterwards: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 wraps naturally to 0x80000000.
    always_comb begin
        neg_a = sgn_q && a_q[31];
        neg_b = sgn_q && b_q[31];
        mag_a = neg_a ? (~a_q + 32'd1) : a_q;
        mag_b = neg_b ? (~b_q + 32'd1) : b_q;
        uquo  = 32'd0;
        urem  = 32'd0;
        if (mag_b != 32'd0) begin
            uquo = mag_a / mag_b;
            urem = mag_a % mag_b;
        end
        quo = (neg_a ^ neg_b) ? (~uquo + 32'd1) : uquo;
        rem = neg_a ? (~urem + 32'd1) : urem;
    end

    // Next-state: accept in IDLE, count down in MUL/DIV, retire on the count==1 edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d = ST_MUL;
                            cnt_d   = MULT_LOAD;
                            sgn_d   = (op == OP_MULT);
                            a_d     = rs_data;
                            b_d     = rt_data;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = ST_DIV;
                            cnt_d   = DIV_LOAD;
                            sgn_d   = (op == OP_DIV);
                            a_d     = rs_data;
                            b_d     = rt_data;
                        end
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q == CNT_ONE) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DIV: begin
                if (cnt_q == CNT_ONE) begin
                    // A zero divisor still spends the full latency but leaves HI/LO alone.
                    if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, operand latches and HI/LO; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: scoreboard of expected HI/LO per op.
// Latency: checks busy every cycle of an op and HI/LO at exactly K+1 cycles.
// Backpressure: exercises dis suppression, ignored starts while busy, and mid-op reset.
module tb_multdiv_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic        dis;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;

    always #5 clk = ~clk;

    multdiv_unit #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .dis     (dis),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour for the randomised ops.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] cur_hi, input logic [31:0] cur_lo);
        exp_t        r;
        logic [63:0] p;
        int          ia, ib;
        r.hi = cur_hi;
        r.lo = cur_lo;
        ia   = a;
        ib   = b;
        case (o)
            OP_MULT: begin
                p    = 64'(longint'(ia) * longint'(ib));
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            OP_MULTU: begin
                p    = {32'd0, a} * {32'd0, b};
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            OP_DIV: begin
                if (b != 32'd0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        r.lo = 32'h8000_0000;
                        r.hi = 32'd0;
                    end else begin
                        r.lo = ia / ib;
                        r.hi = ia % ib;
                    end
                end
            end
            OP_DIVU: begin
                if (b != 32'd0) begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    // Issue one long op; optionally inject a second start in cycle inj_c (which must be ignored).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int inj_c, input logic [2:0] inj_op, input string tag);
        int   k;
        exp_t e;
        k    = (o == OP_DIV || o == OP_DIVU) ? DC : MC;
        e.hi = eh;
        e.lo = el;
        sb.push_back(e);
        @(posedge clk); #1;
        start   = 1'b1;
        dis     = 1'b0;
        op      = o;
        rs_data = a;
        rt_data = b;
        for (int c = 0; c <= k; c++) begin
            @(negedge clk);
            check({tag, "_busy"}, 64'(busy), 64'd1);
            if (c == k) begin
                check({tag, "_hi_early"}, 64'(hi), 64'(m_hi));
                check({tag, "_lo_early"}, 64'(lo), 64'(m_lo));
            end
            @(posedge clk); #1;
            start   = (c + 1 == inj_c);
            op      = (c + 1 == inj_c) ? inj_op : o;
            rs_data = $urandom;
            rt_data = $urandom;
        end
        @(negedge clk);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        e = sb.pop_front();
        check({tag, "_hi"}, 64'(hi), 64'(e.hi));
        check({tag, "_lo"}, 64'(lo), 64'(e.lo));
        m_hi = e.hi;
        m_lo = e.lo;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_hi_hold"}, 64'(hi), 64'(m_hi));
        check({tag, "_lo_hold"}, 64'(lo), 64'(m_lo));
    endtask

    task automatic run_mt(input logic [2:0] o, input logic [31:0] a, input string tag);
        exp_t e;
        e.hi = (o == OP_MTHI) ? a : m_hi;
        e.lo = (o == OP_MTLO) ? a : m_lo;
        sb.push_back(e);
        @(posedge clk); #1;
        start   = 1'b1;
        dis     = 1'b0;
        op      = o;
        rs_data = a;
        @(negedge clk);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        start   = 1'b0;
        rs_data = $urandom;
        @(negedge clk);
        e = sb.pop_front();
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(e.hi));
        check({tag, "_lo"}, 64'(lo), 64'(e.lo));
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        r;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        reset_n = 1'b0;
        start   = 1'b1;
        op      = OP_MULT;
        dis     = 1'b0;
        rs_data = 32'd9;
        rt_data = 32'd9;

        // Reset state, with a start request that must not raise busy.
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, -1, OP_NONE, "mult_neg");
        run_op(OP_DIVU,  32'd7, 32'd2, 32'd1, 32'd3, -1, OP_NONE, "divu_7_2");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, OP_NONE, "div_m7_2");
        run_mt(OP_MTLO,  32'h0000_1234, "mtlo");
        run_mt(OP_MTHI,  32'h0000_CAFE, "mthi");

        // Disabled MULT: never busy, HI/LO untouched.
        @(posedge clk); #1;
        start   = 1'b1;
        dis     = 1'b1;
        op      = OP_MULT;
        rs_data = 32'd100;
        rt_data = 32'd100;
        for (int c = 0; c <= MC + 1; c++) begin
            @(negedge clk);
            check("dis_busy", 64'(busy), 64'd0);
            @(posedge clk); #1;
            start = 1'b0;
            dis   = 1'b0;
        end
        check("dis_hi", 64'(hi), 64'(m_hi));
        check("dis_lo", 64'(lo), 64'(m_lo));
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1, OP_NONE, "multu_max");

        // Divide by zero with a MULT arriving at count 3: full latency, HI/LO unchanged, MULT dropped.
        run_op(OP_DIV,   32'd5, 32'd0, m_hi, m_lo, DC - 2, OP_MULT, "div_zero");
        // Start in the final counter cycle is ignored; the in-flight op retires normally.
        run_op(OP_MULT,  32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, MC, OP_MULTU, "mult_last_start");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, -1, OP_NONE, "div_ovf");
        run_op(OP_DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, -1, OP_NONE, "div_7_m2");

        for (int i = 0; i < 6; i++) begin
            ro = 3'(1 + (i % 4));
            ra = $urandom;
            rb = $urandom;
            if (rb == 32'd0) rb = 32'd1;
            if (i >= 4) rb = rb >> 20;
            if (rb == 32'd0) rb = 32'd3;
            r = model(ro, ra, rb, m_hi, m_lo);
            run_op(ro, ra, rb, r.hi, r.lo, -1, OP_NONE, "rand");
        end

        // Reset in the middle of a DIV (count 4): everything clears immediately.
        @(posedge clk); #1;
        start   = 1'b1;
        op      = OP_DIV;
        rs_data = 32'd100;
        rt_data = 32'd7;
        for (int c = 0; c < DC - 3; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        check("midrst_busy_pre", 64'(busy), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        start = 1'b1;
        op    = OP_MULTU;
        #1;
        check("midrst_busy_start", 64'(busy), 64'd0);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_hi    = 32'd0;
        m_lo    = 32'd0;
        run_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, -1, OP_NONE, "post_rst_multu");

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
